spi_alu_sequencer: RTL and testbench

//  SPI-mode-0 command sequencer for the 4-bit ALU. Receives one 10-bit frame {op[1:0],A[3:0],B[3:0]}
//  and drives the ALU operands, then captures result/flags into registers for the PWM and BCD blocks.

---
 rtl/spi_alu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_spi_alu_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_alu_sequencer.sv
// SPI mode-0 frame receiver that drives the ALU operands and captures its result.
// The previous {result,flags} byte is shifted back out on MISO during each frame.
module spi_alu_sequencer #(
    parameter int DATA_W      = 4,
    parameter int OP_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              i_slk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic              i_sck,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [3:0]        i_alu_flags,
    output logic [DATA_W-1:0] o_result_q,
    output logic [3:0]        o_flags_q,
    output logic              o_valid,
    output logic              o_frame_err
);

    localparam int FRAME_BITS = OP_W + 2 * DATA_W;
    localparam int TX_BITS    = DATA_W + 4;
    localparam int ECNT_W     = $clog2(EXEC_CYCLES + 1);
    localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);
    localparam logic [ECNT_W-1:0] EXEC_LAST = ECNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_EXEC,
        S_CAPTURE
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_cs_s;
    logic [SYNC_STAGES-1:0]  r_sck_s;
    logic [SYNC_STAGES-1:0]  r_mosi_s;
    logic                    r_cs_d;
    logic                    r_sck_d;
    logic [FRAME_BITS-1:0]   r_rx;
    logic [TX_BITS-1:0]      r_tx;
    logic [3:0]              r_cnt;
    logic [ECNT_W-1:0]       r_exec_cnt;
    logic                    r_wait_high;
    logic                    r_miso;
    logic [DATA_W-1:0]       r_alu_a;
    logic [DATA_W-1:0]       r_alu_b;
    logic [OP_W-1:0]         r_alu_op;
    logic [DATA_W-1:0]       r_result_q;
    logic [3:0]              r_flags_q;
    logic                    r_valid;
    logic                    r_frame_err;

    logic w_cs;
    logic w_sck;
    logic w_mosi;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs       = r_cs_s[SYNC_STAGES-1];
    assign w_sck      = r_sck_s[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
    assign w_cs_rise  = w_cs & ~r_cs_d;
    assign w_cs_fall  = ~w_cs & r_cs_d;
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;

    assign o_miso      = r_miso;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_result_q  = r_result_q;
    assign o_flags_q   = r_flags_q;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;

    // CS sync resets low so a CS held low through reset never looks like a fall
    always_ff @(posedge i_slk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cs_s      <= '0;
            r_sck_s     <= '0;
            r_mosi_s    <= '0;
            r_cs_d      <= 1'b0;
            r_sck_d     <= 1'b0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_cnt       <= '0;
            r_exec_cnt  <= '0;
            r_wait_high <= 1'b0;
            r_miso      <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_result_q  <= '0;
            r_flags_q   <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], i_cs};
            r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], i_sck};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], i_mosi};
            r_cs_d   <= w_cs;
            r_sck_d  <= w_sck;
            r_valid  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs) begin
                        r_wait_high <= 1'b0;
                    end
                    if (w_cs_fall && !r_wait_high) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_tx    <= {r_result_q, r_flags_q};
                        r_miso  <= r_result_q[DATA_W-1];
                    end
                end
                S_SHIFT: begin
                    if (w_cs_rise) begin
                        r_miso <= 1'b0;
                        if (r_cnt == FRAME_CNT) begin
                            r_state    <= S_EXEC;
                            r_exec_cnt <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        if (w_sck_rise) begin
                            r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi};
                            if (r_cnt != 4'hF) begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                        if (w_sck_fall) begin
                            r_tx   <= {r_tx[TX_BITS-2:0], 1'b0};
                            r_miso <= r_tx[TX_BITS-2];
                        end
                    end
                end
                S_EXEC: begin
                    if (r_exec_cnt == '0) begin
                        r_alu_op <= r_rx[FRAME_BITS-1 -: OP_W];
                        r_alu_a  <= r_rx[2*DATA_W-1 -: DATA_W];
                        r_alu_b  <= r_rx[DATA_W-1:0];
                    end
                    if (w_cs_fall) begin
                        r_frame_err <= 1'b1;
                        r_wait_high <= 1'b1;
                    end
                    if (r_exec_cnt == EXEC_LAST) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_exec_cnt <= r_exec_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_result_q  <= i_alu_result;
                    r_flags_q   <= i_alu_flags;
                    r_valid     <= 1'b1;
                    r_frame_err <= w_cs_fall | r_wait_high;
                    if (w_cs_fall) begin
                        r_wait_high <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_alu_sequencer.sv
// Directed bench for spi_alu_sequencer with a small behavioural ALU.
// SPI master runs mode 0 at a slow rate relative to the system clock.
module tb_spi_alu_sequencer;

    localparam int HALF = 60;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result;
    logic [3:0] alu_flags;
    logic [3:0] result_q;
    logic [3:0] flags_q;
    logic       valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int v0;
    logic [15:0] so;

    spi_alu_sequencer dut (
        .i_slk        (clk),
        .i_rst        (rst),
        .i_cs         (cs),
        .i_sck        (sck),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .i_alu_flags  (alu_flags),
        .o_result_q   (result_q),
        .o_flags_q    (flags_q),
        .o_valid      (valid),
        .o_frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid === 1'b1) vcnt++;
    end

    // op: 00 add, 01 sub (C = borrow), 10 and, 11 or; flags {N,V,Z,C}
    logic [4:0] sum;
    logic [3:0] res;
    logic       fc;
    logic       fv;
    always_comb begin
        sum = 5'd0;
        res = 4'd0;
        fc  = 1'b0;
        fv  = 1'b0;
        case (alu_op)
            2'b00: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                res = sum[3:0];
                fc  = sum[4];
                fv  = (alu_a[3] == alu_b[3]) && (res[3] != alu_a[3]);
            end
            2'b01: begin
                res = alu_a - alu_b;
                fc  = alu_a < alu_b;
                fv  = (alu_a[3] != alu_b[3]) && (res[3] != alu_a[3]);
            end
            2'b10: res = alu_a & alu_b;
            default: res = alu_a | alu_b;
        endcase
    end
    assign alu_result = res;
    assign alu_flags  = {res[3], fv, res == 4'd0, fc};

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        #(HALF);
    endtask

    task automatic shift_bits(input logic [15:0] bits, input int n,
                              output logic [15:0] sout);
        sout = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #(HALF);
            sck  = 1'b1;
            sout = {sout[14:0], miso};
            #(HALF);
            sck  = 1'b0;
        end
    endtask

    task automatic cs_high();
        #(HALF);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] bits, input int n,
                         output logic [15:0] sout);
        cs_low();
        shift_bits(bits, n, sout);
        cs_high();
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        cs   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;

        // 1: reset with CS high
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_a", 16'(alu_a), 16'h0);
        chk("rst_alu_b", 16'(alu_b), 16'h0);
        chk("rst_alu_op", 16'(alu_op), 16'h0);
        chk("rst_result", 16'(result_q), 16'h0);
        chk("rst_flags", 16'(flags_q), 16'h0);
        chk("rst_err", 16'(frame_err), 16'h0);
        chk("rst_miso", 16'(miso), 16'h0);
        chk("rst_valid_cnt", 16'(vcnt), 16'h0);

        // 2: 1 + 3
        v0 = vcnt;
        frame(16'b00_0001_0011, 10, so);
        chk("f1_miso", so, 16'h0);
        chk("f1_op", 16'(alu_op), 16'h0);
        chk("f1_a", 16'(alu_a), 16'h1);
        chk("f1_b", 16'(alu_b), 16'h3);
        chk("f1_result", 16'(result_q), 16'h4);
        chk("f1_flags", 16'(flags_q), 16'h0);
        chk("f1_valid_cycles", 16'(vcnt - v0), 16'h1);
        chk("f1_err", 16'(frame_err), 16'h0);
        chk("f1_miso_idle", 16'(miso), 16'h0);

        // 3: 3 - 1, previous result streams out
        v0 = vcnt;
        frame(16'b01_0011_0001, 10, so);
        chk("f2_miso", so, 16'b0100_0000_00);
        chk("f2_op", 16'(alu_op), 16'h1);
        chk("f2_result", 16'(result_q), 16'h2);
        chk("f2_flags", 16'(flags_q), 16'h0);
        chk("f2_valid_cycles", 16'(vcnt - v0), 16'h1);

        // 4: short frame, then a good AND frame
        v0 = vcnt;
        frame(16'b101_1111, 7, so);
        chk("short_err", 16'(frame_err), 16'h1);
        chk("short_op", 16'(alu_op), 16'h1);
        chk("short_a", 16'(alu_a), 16'h3);
        chk("short_b", 16'(alu_b), 16'h1);
        chk("short_result", 16'(result_q), 16'h2);
        chk("short_valid", 16'(vcnt - v0), 16'h0);
        v0 = vcnt;
        frame(16'b10_1100_1010, 10, so);
        chk("f3_miso", so, 16'b0010_0000_00);
        chk("f3_op", 16'(alu_op), 16'h2);
        chk("f3_a", 16'(alu_a), 16'hC);
        chk("f3_b", 16'(alu_b), 16'hA);
        chk("f3_result", 16'(result_q), 16'h8);
        chk("f3_flags", 16'(flags_q), 16'b1000);
        chk("f3_err_clr", 16'(frame_err), 16'h0);
        chk("f3_valid_cycles", 16'(vcnt - v0), 16'h1);

        // 5: long frame
        v0 = vcnt;
        frame(16'hABC, 12, so);
        chk("long_err", 16'(frame_err), 16'h1);
        chk("long_result", 16'(result_q), 16'h8);
        chk("long_flags", 16'(flags_q), 16'b1000);
        chk("long_a", 16'(alu_a), 16'hC);
        chk("long_valid", 16'(vcnt - v0), 16'h0);

        // 6: reset mid-frame with CS held low
        cs_low();
        shift_bits(16'b00_001, 5, so);
        do_reset();
        chk("mid_rst_result", 16'(result_q), 16'h0);
        chk("mid_rst_flags", 16'(flags_q), 16'h0);
        chk("mid_rst_a", 16'(alu_a), 16'h0);
        chk("mid_rst_op", 16'(alu_op), 16'h0);
        chk("mid_rst_err", 16'(frame_err), 16'h0);
        chk("mid_rst_miso", 16'(miso), 16'h0);
        v0 = vcnt;
        @(negedge clk);
        shift_bits(16'b1_0001, 5, so);
        cs_high();
        chk("orphan_valid", 16'(vcnt - v0), 16'h0);
        chk("orphan_result", 16'(result_q), 16'h0);
        chk("orphan_err", 16'(frame_err), 16'h0);
        chk("orphan_a", 16'(alu_a), 16'h0);
        v0 = vcnt;
        frame(16'b00_0010_0010, 10, so);
        chk("f4_miso", so, 16'h0);
        chk("f4_result", 16'(result_q), 16'h4);
        chk("f4_a", 16'(alu_a), 16'h2);
        chk("f4_valid_cycles", 16'(vcnt - v0), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
